// File: rtl/exc_commit_cp0.sv
// rtl/exc_commit_cp0.sv - commit-stage exception/eret resolution with CP0 register file
// Optional CP0_TIMER_EN adds the Count/Compare timer interrupt on IP[15].
module exc_commit_cp0 (
  input  logic        clk,
  input  logic        resetn,
  input  logic        wb_valid,
  input  logic [8:0]  except,
  input  logic [31:0] wb_pc,
  input  logic        wb_bd,
  input  logic [31:0] wb_badaddr,
  input  logic [5:0]  hw_int,
  input  logic        mtc0_we,
  input  logic [4:0]  cp0_addr,
  input  logic [31:0] cp0_wdata,
  output logic [31:0] cp0_rdata,
  output logic        flush,
  output logic [31:0] redirect_pc
);

  localparam logic [0:0]  ST_IDLE  = 1'b0;
  localparam logic [0:0]  ST_FLUSH = 1'b1;

  localparam logic [4:0]  A_BADVADDR = 5'd8;
  localparam logic [4:0]  A_COUNT    = 5'd9;
  localparam logic [4:0]  A_COMPARE  = 5'd11;
  localparam logic [4:0]  A_STATUS   = 5'd12;
  localparam logic [4:0]  A_CAUSE    = 5'd13;
  localparam logic [4:0]  A_EPC      = 5'd14;

  localparam logic [31:0] EXC_VECTOR = 32'hBFC0_0380;

  logic [0:0]  state;
  logic [7:0]  st_im;
  logic        st_exl;
  logic        st_ie;
  logic        ca_bd;
  logic        ca_ti;
  logic [1:0]  ca_ipsw;
  logic [4:0]  ca_code;
  logic [31:0] epc;
  logic [31:0] badvaddr;
  logic [31:0] count;
  logic [31:0] compare;
  logic [7:0]  ip;

  logic        live;
  logic        int_req;
  logic        exc_hit;
  logic [4:0]  exc_code;
  logic        bva_pc;
  logic        bva_data;
  logic        take_exc;
  logic        take_eret;
  logic        do_mtc0;
  logic        unused_bits;

  // The squashed instruction in the flush cycle must not commit anything.
  assign live      = wb_valid & (state == ST_IDLE);
  assign int_req   = st_ie & ~st_exl & (|(ip & st_im));
  assign take_exc  = live & exc_hit;
  assign take_eret = live & ~exc_hit & except[8];
  assign do_mtc0   = live & mtc0_we & ~exc_hit & ~except[8];

  always_comb begin
    exc_hit  = 1'b1;
    exc_code = 5'h00;
    bva_pc   = 1'b0;
    bva_data = 1'b0;
    if (int_req) begin
      exc_code = 5'h00;
    end else if (except[7]) begin
      exc_code = 5'h04;
      bva_pc   = 1'b1;
    end else if (except[6]) begin
      exc_code = 5'h0A;
    end else if (except[5]) begin
      exc_code = 5'h0C;
    end else if (except[4]) begin
      exc_code = 5'h08;
    end else if (except[3]) begin
      exc_code = 5'h09;
    end else if (except[2]) begin
      exc_code = 5'h04;
      bva_data = 1'b1;
    end else if (except[1]) begin
      exc_code = 5'h05;
      bva_data = 1'b1;
    end else begin
      exc_hit  = 1'b0;
    end
  end

`ifdef CP0_TIMER_EN
  logic tick;
  logic wr_count;
  logic wr_compare;

  assign wr_count    = do_mtc0 & (cp0_addr == A_COUNT);
  assign wr_compare  = do_mtc0 & (cp0_addr == A_COMPARE);
  assign ip          = {ca_ti, hw_int[4:0], ca_ipsw};
  assign unused_bits = except[0] ^ hw_int[5];

  // Software writes override the free-running increment in the same cycle.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      count   <= '0;
      compare <= '0;
      tick    <= 1'b0;
      ca_ti   <= 1'b0;
    end else begin
      tick <= ~tick;
      if (tick) begin
        count <= count + 32'd1;
      end
      if (wr_count) begin
        count <= cp0_wdata;
        tick  <= 1'b0;
      end
      if (wr_compare) begin
        compare <= cp0_wdata;
      end
      if (wr_compare) begin
        ca_ti <= 1'b0;
      end else if (count == compare) begin
        ca_ti <= 1'b1;
      end
    end
  end
`else
  assign count       = '0;
  assign compare     = '0;
  assign ca_ti       = 1'b0;
  assign ip          = {hw_int, ca_ipsw};
  assign unused_bits = except[0];
`endif

  always_comb begin
    cp0_rdata = '0;
    case (cp0_addr)
      A_BADVADDR: cp0_rdata = badvaddr;
      A_COUNT:    cp0_rdata = count;
      A_COMPARE:  cp0_rdata = compare;
      A_STATUS:   cp0_rdata = {9'b0, 1'b1, 6'b0, st_im, 6'b0, st_exl, st_ie};
      A_CAUSE:    cp0_rdata = {ca_bd, ca_ti, 14'b0, ip, 1'b0, ca_code, 2'b0};
      A_EPC:      cp0_rdata = epc;
      default:    cp0_rdata = '0;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state       <= ST_IDLE;
      flush       <= 1'b0;
      redirect_pc <= '0;
      st_im       <= '0;
      st_exl      <= 1'b0;
      st_ie       <= 1'b0;
      ca_bd       <= 1'b0;
      ca_ipsw     <= '0;
      ca_code     <= '0;
      epc         <= '0;
      badvaddr    <= '0;
    end else begin
      state <= ST_IDLE;
      flush <= 1'b0;
      if (take_exc) begin
        state       <= ST_FLUSH;
        flush       <= 1'b1;
        redirect_pc <= EXC_VECTOR;
        ca_code     <= exc_code;
        st_exl      <= 1'b1;
        // A nested exception keeps the original return point.
        if (!st_exl) begin
          epc   <= wb_bd ? (wb_pc - 32'd4) : wb_pc;
          ca_bd <= wb_bd;
        end
        if (bva_pc) begin
          badvaddr <= wb_pc;
        end else if (bva_data) begin
          badvaddr <= wb_badaddr;
        end
      end else if (take_eret) begin
        state       <= ST_FLUSH;
        flush       <= 1'b1;
        redirect_pc <= epc;
        st_exl      <= 1'b0;
      end else if (do_mtc0) begin
        case (cp0_addr)
          A_BADVADDR: badvaddr <= cp0_wdata;
          A_STATUS: begin
            st_im  <= cp0_wdata[15:8];
            st_exl <= cp0_wdata[1];
            st_ie  <= cp0_wdata[0];
          end
          A_CAUSE:    ca_ipsw <= cp0_wdata[9:8];
          A_EPC:      epc <= cp0_wdata;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: doc/exc_commit_cp0.md
EXC_COMMIT_CP0 -- requirements
Module: exc_commit_cp0

Interface
REQ-001 clk  in  1  single clock; all state updates on rising edge.
REQ-002 resetn  in  1  reset, asynchronous, active-low.
REQ-003 wb_valid  in  1  commit-stage instruction valid this cycle.
REQ-004 except  in  9  exception vector: [8] eret, [7] fetch AdEL (misaligned PC), [6] RI, [5] Ov, [4] syscall, [3] break, [2] load AdEL, [1] store AdES, [0] reserved (ignored).
REQ-005 wb_pc  in  32  PC of committing instruction.
REQ-006 wb_bd  in  1  committing instruction is in a branch delay slot.
REQ-007 wb_badaddr  in  32  faulting data address for except[2]/[1].
REQ-008 hw_int  in  6  external interrupt lines, level, active-high.
REQ-009 mtc0_we  in  1  CP0 write strobe; cp0_addr  in  5; cp0_wdata  in  32.
REQ-010 cp0_rdata  out  32  combinational read of register at cp0_addr.
REQ-011 flush  out  1  registered pipeline flush pulse.
REQ-012 redirect_pc  out  32  registered fetch target, valid while flush=1.

Function
REQ-013 Registers: BadVAddr(8), Count(9), Compare(11), Status(12), Cause(13), EPC(14); other addresses read 0, writes ignored.
REQ-014 Status fields: BEV[22], IM[15:8], EXL[1], IE[0] writable; other bits read 0 (BEV read-only 1).
REQ-015 Cause fields: BD[31], TI[30], IP[15:10]=hw_int (IP[15] see REQ-030), IP[9:8] software-writable, ExcCode[6:2]; other bits 0.
REQ-016 int_req = Status.IE & ~Status.EXL & |(Cause.IP & Status.IM), sampled only when wb_valid=1.
REQ-017 Priority, highest first: int_req (code 0x00), except[7] (0x04), [6] (0x0A), [5] (0x0C), [4] (0x08), [3] (0x09), [2] (0x04), [1] (0x05); eret handled only if none of these.
REQ-018 On accepted exception: Cause.ExcCode<=code; if Status.EXL=0 then EPC<=wb_bd?wb_pc-4:wb_pc and Cause.BD<=wb_bd, else EPC/BD unchanged; Status.EXL<=1.
REQ-019 BadVAddr<=wb_pc for except[7]; <=wb_badaddr for except[2]/[1]; unchanged otherwise.
REQ-020 Exception redirect_pc = 32'hBFC0_0380.
REQ-021 On accepted eret: Status.EXL<=0, redirect_pc=EPC (value before this edge).
REQ-022 State machine: IDLE -> FLUSH on accepted exception/eret; FLUSH -> IDLE unconditionally after one cycle.
REQ-023 Latency: event committed in cycle T => flush=1 and redirect_pc valid exactly in cycle T+1; flush never high two consecutive cycles.
REQ-024 In FLUSH, wb_valid/except/mtc0_we ignored (squashed instruction).
REQ-025 mtc0 with wb_valid=1 and simultaneous accepted exception: write dropped; exception updates take effect.
REQ-026 mtc0 to EPC same cycle as eret: eret uses old EPC, write dropped.
REQ-027 wb_valid=0: no exception, eret, or mtc0 takes effect.

Reset
REQ-028 resetn=0 asynchronously: state=IDLE, flush=0, redirect_pc=0, Status=32'h0040_0000, Cause=0, EPC=0, BadVAddr=0, Count=0, Compare=0, tick=0.
REQ-029 Reset asserted in FLUSH aborts the pulse; first cycle after deassert is IDLE with flush=0.

Configuration
REQ-030 Macro CP0_TIMER_EN defined: Count increments every second clk (internal tick toggle); Count==Compare sets Cause.TI, drives IP[15]; mtc0 to Compare clears TI; mtc0 to Count loads value and resets tick; mtc0 and increment same cycle: write wins.
REQ-031 CP0_TIMER_EN undefined: Count/Compare read 0, writes ignored, TI=0, IP[15]=hw_int[5].

Verification
REQ-032 Reset, wb_valid=1, except=9'h080, wb_pc=32'h0000_1002, bd=0 -> next cycle flush=1, redirect_pc=BFC0_0380; then EPC=0000_1002, BadVAddr=0000_1002, ExcCode=0x04, EXL=1.
REQ-033 except=9'h010, wb_pc=32'h0000_2004, bd=1 -> EPC=0000_2000, BD=1, ExcCode=0x08; then eret -> flush, redirect_pc=0000_2000, EXL=0.
REQ-034 except=9'h0C0 (fetch AdEL + RI) -> ExcCode=0x04 only.
REQ-035 Status=32'h0000_0401, hw_int=6'h01, wb_valid=1, except=9'h020 -> ExcCode=0x00 (interrupt beats Ov); second exception with EXL=1 leaves EPC unchanged.
REQ-036 With CP0_TIMER_EN: Compare=5, Count=0 -> TI=1 after 10 cycles; mtc0 Compare -> TI=0; resetn pulse mid-FLUSH -> flush=0 immediately.
